alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/alu_operand_loader.sv | 144 ++++++++++++++
 tb/tb_alu_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand loader for a board-driven ALU: synchronised push-buttons step an FSM that
// latches A, B and the opcode from switches, then captures the ALU result for display.
`timescale 1ns/1ps

module alu_operand_loader_btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);
   logic [1:0] sync_pipe;
   logic       prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_pipe <= '0;
         prev      <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[0], btn};
         prev      <= sync_pipe[1];
      end
   end

   // Rising edge of the synchronised level; a held button yields a single pulse.
   assign press = sync_pipe[1] & ~prev;
endmodule

module alu_operand_loader #(
   parameter int N_BITS  = 8,
   parameter int OP_BITS = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_BITS-1:0]  sw,
   input  logic               btn_load,
   input  logic               btn_clear,
   input  logic [N_BITS-1:0]  alu_result,
   output logic [N_BITS-1:0]  data_a,
   output logic [N_BITS-1:0]  data_b,
   output logic [OP_BITS-1:0] op_code,
   output logic [N_BITS-1:0]  result_q,
   output logic               result_valid,
   output logic [2:0]         state_q
);
   typedef enum logic [2:0] {
      LOAD_A  = 3'd0,
      LOAD_B  = 3'd1,
      LOAD_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   typedef struct packed {
      logic [N_BITS-1:0]  a;
      logic [N_BITS-1:0]  b;
      logic [OP_BITS-1:0] op;
      logic [N_BITS-1:0]  res;
      logic               vld;
   } regs_t;

   state_t     state, state_nxt;
   regs_t      regs, regs_nxt;
   logic [1:0] btn_raw, btn_ev;
   logic       ld_ev, clr_ev;

   assign btn_raw = {btn_clear, btn_load};

   for (genvar g = 0; g < 2; g++) begin : g_sync
      alu_operand_loader_btn_sync u_sync (
         .clk   (clk),
         .reset (reset),
         .btn   (btn_raw[g]),
         .press (btn_ev[g])
      );
   end

   assign ld_ev  = btn_ev[0];
   assign clr_ev = btn_ev[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOAD_A;
         regs  <= '0;
      end else begin
         state <= state_nxt;
         regs  <= regs_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      regs_nxt  = regs;
      if (clr_ev) begin
         state_nxt = LOAD_A;
         regs_nxt  = '0;
      end else begin
         case (state)
            LOAD_A: begin
               regs_nxt.vld = 1'b0;
               if (ld_ev) begin
                  regs_nxt.a = sw;
                  state_nxt  = LOAD_B;
               end
            end
            LOAD_B: begin
               regs_nxt.vld = 1'b0;
               if (ld_ev) begin
                  regs_nxt.b = sw;
                  state_nxt  = LOAD_OP;
               end
            end
            LOAD_OP: begin
               regs_nxt.vld = 1'b0;
               if (ld_ev) begin
                  regs_nxt.op = sw[OP_BITS-1:0];
                  state_nxt   = EXEC;
               end
            end
            // Single capture cycle; a load event here is deliberately dropped.
            EXEC: begin
               regs_nxt.res = alu_result;
               regs_nxt.vld = 1'b1;
               state_nxt    = SHOW;
            end
            // Chaining: the shown result becomes the next A operand.
            SHOW: begin
               if (ld_ev) begin
                  regs_nxt.vld = 1'b0;
                  regs_nxt.a   = regs.res;
                  state_nxt    = LOAD_B;
               end
            end
            default: state_nxt = LOAD_A;
         endcase
      end
   end

   assign data_a       = regs.a;
   assign data_b       = regs.b;
   assign op_code      = regs.op;
   assign result_q     = regs.res;
   assign result_valid = regs.vld;
   assign state_q      = state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Table-driven bench for alu_operand_loader with a scoreboard of expected output sets
// and hand-written sequences for button timing, clear, and asynchronous reset.
`timescale 1ns/1ps

module tb_alu_operand_loader;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] sw = '0;
   logic       btn_load = 1'b0;
   logic       btn_clear = 1'b0;
   logic [7:0] alu_result;
   logic [7:0] data_a, data_b, result_q;
   logic [5:0] op_code;
   logic       result_valid;
   logic [2:0] state_q;

   alu_operand_loader #(.N_BITS(8), .OP_BITS(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .sw           (sw),
      .btn_load     (btn_load),
      .btn_clear    (btn_clear),
      .alu_result   (alu_result),
      .data_a       (data_a),
      .data_b       (data_b),
      .op_code      (op_code),
      .result_q     (result_q),
      .result_valid (result_valid),
      .state_q      (state_q)
   );

   always #5 clk = ~clk;

   // Stand-in for the ALU under control.
   always_comb begin
      case (op_code)
         6'h20:   alu_result = data_a + data_b;
         6'h22:   alu_result = data_a - data_b;
         default: alu_result = data_a ^ data_b;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] res;
      logic       vld;
      logic [2:0] st;
   } exp_t;

   typedef struct {
      bit         press;
      logic [7:0] sw;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[12];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic exp_t mk_exp(logic [7:0] a, logic [7:0] b, logic [5:0] op,
                                   logic [7:0] res, logic vld, logic [2:0] st);
      exp_t e;
      e.a = a; e.b = b; e.op = op; e.res = res; e.vld = vld; e.st = st;
      return e;
   endfunction

   function automatic vec_t mk_vec(bit p, logic [7:0] s, exp_t e);
      vec_t v;
      v.press = p; v.sw = s; v.e = e;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_out(string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, ".data_a"},       32'(data_a),       32'(e.a));
         chk({tag, ".data_b"},       32'(data_b),       32'(e.b));
         chk({tag, ".op_code"},      32'(op_code),      32'(e.op));
         chk({tag, ".result_q"},     32'(result_q),     32'(e.res));
         chk({tag, ".result_valid"}, 32'(result_valid), 32'(e.vld));
         chk({tag, ".state_q"},      32'(state_q),      32'(e.st));
      end
   endtask

   // Called just after an edge; returns one sample-delay after the action edge.
   task automatic press(input logic ld, input logic cl, input logic [7:0] v);
      sw = v; btn_load = ld; btn_clear = cl;
      @(posedge clk); #1;
      btn_load = 1'b0; btn_clear = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk_vec(1, 8'h05, mk_exp(8'h05, 8'h00, 6'h00, 8'h00, 0, 3'd1));
      tbl[1]  = mk_vec(1, 8'h03, mk_exp(8'h05, 8'h03, 6'h00, 8'h00, 0, 3'd2));
      tbl[2]  = mk_vec(1, 8'h20, mk_exp(8'h05, 8'h03, 6'h20, 8'h00, 0, 3'd3));
      tbl[3]  = mk_vec(0, 8'h20, mk_exp(8'h05, 8'h03, 6'h20, 8'h08, 1, 3'd4));
      tbl[4]  = mk_vec(1, 8'h00, mk_exp(8'h08, 8'h03, 6'h20, 8'h08, 0, 3'd1));
      tbl[5]  = mk_vec(1, 8'h02, mk_exp(8'h08, 8'h02, 6'h20, 8'h08, 0, 3'd2));
      tbl[6]  = mk_vec(1, 8'h22, mk_exp(8'h08, 8'h02, 6'h22, 8'h08, 0, 3'd3));
      tbl[7]  = mk_vec(0, 8'h22, mk_exp(8'h08, 8'h02, 6'h22, 8'h06, 1, 3'd4));
      tbl[8]  = mk_vec(1, 8'h00, mk_exp(8'h06, 8'h02, 6'h22, 8'h06, 0, 3'd1));
      tbl[9]  = mk_vec(1, 8'h10, mk_exp(8'h06, 8'h10, 6'h22, 8'h06, 0, 3'd2));
      tbl[10] = mk_vec(1, 8'hFF, mk_exp(8'h06, 8'h10, 6'h3F, 8'h06, 0, 3'd3));
      tbl[11] = mk_vec(0, 8'hFF, mk_exp(8'h06, 8'h10, 6'h3F, 8'h16, 1, 3'd4));

      // Reset state
      #12;
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      check_out("reset");
      @(negedge clk); reset = 1'b1;
      tick();

      // Load / execute / chain sequence
      for (int i = 0; i < 12; i++) begin
         sb.push_back(tbl[i].e);
         if (tbl[i].press) press(1'b1, 1'b0, tbl[i].sw);
         else tick();
         check_out($sformatf("vec%0d", i));
      end

      // Short reset pulse between edges while in SHOW: outputs clear at once
      #2 reset = 1'b0;
      #0.5;
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      check_out("async_rst");
      #0.5 reset = 1'b1;
      tick();
      sb.push_back(mk_exp(8'h77, 0, 0, 0, 0, 3'd1));
      press(1'b1, 1'b0, 8'h77);
      check_out("post_rst_load");

      // One-cycle pulse: action exactly on the third edge
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      press(1'b0, 1'b1, 8'h00);
      check_out("clear1");
      sw = 8'h5A; btn_load = 1'b1;
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      tick(); btn_load = 1'b0;
      check_out("edge1");
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      tick();
      check_out("edge2");
      sb.push_back(mk_exp(8'h5A, 0, 0, 0, 0, 3'd1));
      tick();
      check_out("edge3");
      sb.push_back(mk_exp(8'h5A, 0, 0, 0, 0, 3'd1));
      repeat (4) tick();
      check_out("pulse_once");

      // Button held 50 cycles in LOAD_A: a single load of A
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      press(1'b0, 1'b1, 8'h00);
      check_out("clear2");
      sb.push_back(mk_exp(8'hAA, 0, 0, 0, 0, 3'd1));
      sw = 8'hAA; btn_load = 1'b1;
      repeat (10) tick();
      sw = 8'h55;
      repeat (40) tick();
      btn_load = 1'b0;
      repeat (4) tick();
      check_out("held_btn");

      // Clear and load together in LOAD_OP: clear wins
      sb.push_back(mk_exp(8'hAA, 8'h11, 0, 0, 0, 3'd2));
      press(1'b1, 1'b0, 8'h11);
      check_out("to_load_op");
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      press(1'b1, 1'b1, 8'h22);
      check_out("clr_vs_load");

      // Reset during EXEC: no capture, next load goes to A
      press(1'b1, 1'b0, 8'h01);
      press(1'b1, 1'b0, 8'h02);
      sb.push_back(mk_exp(8'h01, 8'h02, 6'h20, 0, 0, 3'd3));
      press(1'b1, 1'b0, 8'h20);
      check_out("in_exec");
      #1 reset = 1'b0;
      #1 reset = 1'b1;
      sb.push_back(mk_exp(0, 0, 0, 0, 0, 3'd0));
      tick();
      check_out("exec_abort");
      sb.push_back(mk_exp(8'h09, 0, 0, 0, 0, 3'd1));
      press(1'b1, 1'b0, 8'h09);
      check_out("exec_abort_load");

      // Button already held at reset release: one event
      reset = 1'b0; btn_load = 1'b1; sw = 8'h33;
      #3 reset = 1'b1;
      repeat (3) tick();
      sw = 8'h44;
      repeat (5) tick();
      btn_load = 1'b0;
      tick();
      sb.push_back(mk_exp(8'h33, 0, 0, 0, 0, 3'd1));
      check_out("held_at_release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
